lsu_bus_ctrl: RTL

- Data-side responder for the core's memory control strobes (mem_rd / mem_wr).
- Accepts one load or store from the execute/memory stage and stalls the pipeline while the access runs.
- Converts the access into a single word-aligned transaction on the SoC data bus (req/gnt request phase, rvalid response phase).
- Returns sign/zero-extended load data, and flags misaligned, illegal or timed-out accesses.

---
 rtl/lsu_bus_ctrl_pkg.sv | 22 ++
 rtl/lsu_bus_ctrl_align.sv | 68 ++++++
 rtl/lsu_bus_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/lsu_bus_ctrl_pkg.sv
// Shared definitions for the LSU bus controller: access size codes,
// byte-enable base patterns and the controller FSM state type.
package lsu_bus_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/lsu_bus_ctrl_align.sv
// Lane steering for the LSU: store byte-enable/data replication with
// misalign/illegal detection, and load byte/half extraction with extension.
module lsu_align
  import lsu_bus_ctrl_pkg::*;
(
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [1:0]  req_addr_lo_i,
  input  logic [31:0] req_wdata_i,
  output logic [3:0]  req_be_o,
  output logic [31:0] req_wdata_o,
  output logic        req_bad_o,
  input  logic [2:0]  rsp_funct3_i,
  input  logic [1:0]  rsp_addr_lo_i,
  input  logic [31:0] rsp_rdata_i,
  output logic [31:0] rsp_data_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_be_o    = '0;
    req_wdata_o = req_wdata_i;
    req_bad_o   = 1'b0;
    case (req_funct3_i)
      F3_B, F3_BU: begin
        req_be_o    = BE_BYTE << req_addr_lo_i;
        req_wdata_o = {4{req_wdata_i[7:0]}};
        req_bad_o   = req_we_i && (req_funct3_i == F3_BU);
      end
      F3_H, F3_HU: begin
        req_be_o    = BE_HALF << req_addr_lo_i;
        req_wdata_o = {2{req_wdata_i[15:0]}};
        req_bad_o   = req_addr_lo_i[0] || (req_we_i && (req_funct3_i == F3_HU));
      end
      F3_W: begin
        req_be_o  = BE_WORD;
        req_bad_o = |req_addr_lo_i;
      end
      default: req_bad_o = 1'b1;
    endcase
  end

  always_comb begin
    case (rsp_addr_lo_i)
      2'd0:    lane_b = rsp_rdata_i[7:0];
      2'd1:    lane_b = rsp_rdata_i[15:8];
      2'd2:    lane_b = rsp_rdata_i[23:16];
      default: lane_b = rsp_rdata_i[31:24];
    endcase
    lane_h = rsp_addr_lo_i[1] ? rsp_rdata_i[31:16] : rsp_rdata_i[15:0];
  end

  always_comb begin
    case (rsp_funct3_i)
      F3_B:    rsp_data_o = {{24{lane_b[7]}}, lane_b};
      F3_H:    rsp_data_o = {{16{lane_h[15]}}, lane_h};
      F3_W:    rsp_data_o = rsp_rdata_i;
      F3_BU:   rsp_data_o = {24'h0, lane_b};
      F3_HU:   rsp_data_o = {16'h0, lane_h};
      default: rsp_data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Data-side LSU: turns one mem_rd/mem_wr strobe into a single word-aligned
// req/gnt/rvalid bus transaction, stalling the pipeline until it completes.
module lsu_bus_ctrl
  import lsu_bus_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_rd_i,
  input  logic              mem_wr_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [31:0]       bus_rdata_i
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_pend_q, err_pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic        al_bad;
  logic [31:0] al_rsp;
  logic        tmo_hit;

  lsu_align u_align (
    .req_we_i      (mem_wr_i),
    .req_funct3_i  (funct3_i),
    .req_addr_lo_i (addr_i[1:0]),
    .req_wdata_i   (wdata_i),
    .req_be_o      (al_be),
    .req_wdata_o   (al_wdata),
    .req_bad_o     (al_bad),
    .rsp_funct3_i  (funct3_q),
    .rsp_addr_lo_i (addr_q[1:0]),
    .rsp_rdata_i   (bus_rdata_i),
    .rsp_data_o    (al_rsp)
  );

  assign tmo_hit = (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_pend_d = err_pend_q;
    stall_o    = 1'b0;
    cnt_d      = (state_q == S_REQ || state_q == S_WAIT) ? cnt_q + CNT_W'(1) : '0;

    case (state_q)
      S_IDLE: begin
        stall_o = mem_rd_i | mem_wr_i;
        if (mem_rd_i || mem_wr_i) begin
          we_d       = mem_wr_i;
          funct3_d   = funct3_i;
          addr_d     = addr_i;
          be_d       = al_be;
          wdata_d    = al_wdata;
          err_pend_d = al_bad;
          state_d    = al_bad ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        stall_o = 1'b1;
        // A grant racing the last timeout cycle still aborts; its late
        // rvalid is dropped because the FSM is no longer in WAIT.
        if (tmo_hit) begin
          state_d    = S_DONE;
          err_pend_d = 1'b1;
          if (!we_q) rdata_d = '0;
        end else if (bus_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        stall_o = 1'b1;
        if (bus_rvalid_i) begin
          state_d = S_DONE;
          if (!we_q) rdata_d = al_rsp;
        end else if (tmo_hit) begin
          state_d    = S_DONE;
          err_pend_d = 1'b1;
          if (!we_q) rdata_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_pend_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_pend_q <= err_pend_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rdata_o     = rdata_q;
  assign err_o       = (state_q == S_DONE) && err_pend_q;
  assign bus_req_o   = (state_q == S_REQ);
  assign bus_we_o    = we_q;
  assign bus_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_be_o    = be_q;
  assign bus_wdata_o = wdata_q;

endmodule
